// File: rtl/tl_pkg.sv
// tl_pkg: constants shared by the sensor conditioning stage and the
// left-turn controller bench.
//   TL_PRESCALE  default clock cycles per debounce sample tick
//   TL_DEBOUNCE  default consecutive ticks required to accept a new level
//   TL_SENS_*    sensor index ordering (A, B, A-left, B-left)
package tl_pkg;

  localparam int unsigned TL_PRESCALE = 4;
  localparam int unsigned TL_DEBOUNCE = 3;

  localparam int unsigned TL_SENS_A  = 0;
  localparam int unsigned TL_SENS_B  = 1;
  localparam int unsigned TL_SENS_AL = 2;
  localparam int unsigned TL_SENS_BL = 3;
  localparam int unsigned TL_NUM_SENS = 4;

endpackage

// File: rtl/tl_debounce_ch.sv
// tl_debounce_ch: one loop-sensor channel. Two-flop synchronizer followed by
// a tick-qualified debounce counter; the output only follows the synchronized
// level after it has differed from the output for DEBOUNCE consecutive ticks.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   tick     sample strobe from the shared prescaler
//   raw      asynchronous sensor input
//   clean    registered, debounced level
module tl_debounce_ch
  import tl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = TL_DEBOUNCE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic clean
);

  localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_out;
  logic [DW-1:0] r_dcnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_out  <= 1'b0;
      r_dcnt <= '0;
    end else begin
      // Synchronizer runs every cycle, independent of the tick.
      r_s1 <= raw;
      r_s2 <= r_s1;
      if (tick) begin
        if (r_s2 == r_out) begin
          // Any sample matching the output restarts the count.
          r_dcnt <= '0;
        end else if (r_dcnt == DMAX) begin
          r_out  <= r_s2;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end
    end
  end

  assign clean = r_out;

endmodule

// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: conditions the four raw loop-sensor inputs of the left-turn
// traffic light controller. A shared prescaler generates the sample tick; each
// channel is synchronized and debounced independently.
// Ports:
//   clk, reset_n              clock and synchronous active-low reset
//   raw_a/raw_b/raw_al/raw_bl asynchronous sensor inputs
//   Ta/Tb/Tal/Tbl             debounced traffic-present outputs
//   tick                      one-cycle sample strobe (pcnt == PRESCALE-1)
module tl_sensor_cond
  import tl_pkg::*;
#(
  parameter int unsigned PRESCALE = TL_PRESCALE,
  parameter int unsigned DEBOUNCE = TL_DEBOUNCE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_al,
  input  logic raw_bl,
  output logic Ta,
  output logic Tb,
  output logic Tal,
  output logic Tbl,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_tick;
  logic [TL_NUM_SENS-1:0] w_raw;
  logic [TL_NUM_SENS-1:0] w_clean;

  // With PRESCALE=1 the counter never leaves 0, so the tick is always high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pcnt <= '0;
    end else if (r_pcnt == PMAX) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  assign w_tick = (r_pcnt == PMAX);
  assign tick   = w_tick;

  assign w_raw[TL_SENS_A]  = raw_a;
  assign w_raw[TL_SENS_B]  = raw_b;
  assign w_raw[TL_SENS_AL] = raw_al;
  assign w_raw[TL_SENS_BL] = raw_bl;

  for (genvar g = 0; g < TL_NUM_SENS; g++) begin : g_ch
    tl_debounce_ch #(.DEBOUNCE(DEBOUNCE)) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (w_tick),
      .raw    (w_raw[g]),
      .clean  (w_clean[g])
    );
  end

  assign Ta  = w_clean[TL_SENS_A];
  assign Tb  = w_clean[TL_SENS_B];
  assign Tal = w_clean[TL_SENS_AL];
  assign Tbl = w_clean[TL_SENS_BL];

endmodule

// File: tb/tb_tl_sensor_cond.sv
// tb_tl_sensor_cond: directed bench for tl_sensor_cond. One instance uses the
// default PRESCALE=4/DEBOUNCE=3, a second uses PRESCALE=1/DEBOUNCE=1.
// Cycle k is the interval whose values are captured at rising edge k, where
// edge 0 is the first edge with reset_n=1. Inputs are driven and outputs
// sampled 1 time unit after the preceding rising edge.
module tb_tl_sensor_cond;

  logic clk = 1'b0;
  logic reset_n;
  logic raw_a, raw_b, raw_al, raw_bl;
  logic Ta, Tb, Tal, Tbl, tick;

  logic raw1_a;
  logic zero = 1'b0;
  logic Ta1, Tb1, Tal1, Tbl1, tick1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  tl_sensor_cond #(.PRESCALE(4), .DEBOUNCE(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .raw_a(raw_a), .raw_b(raw_b), .raw_al(raw_al), .raw_bl(raw_bl),
    .Ta(Ta), .Tb(Tb), .Tal(Tal), .Tbl(Tbl), .tick(tick)
  );

  tl_sensor_cond #(.PRESCALE(1), .DEBOUNCE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .raw_a(raw1_a), .raw_b(zero), .raw_al(zero), .raw_bl(zero),
    .Ta(Ta1), .Tb(Tb1), .Tal(Tal1), .Tbl(Tbl1), .tick(tick1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  // Reset for n edges with all raw inputs low; returns positioned in cycle 0.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    raw_a = 1'b0; raw_b = 1'b0; raw_al = 1'b0; raw_bl = 1'b0;
    raw1_a = 1'b0;
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [23:0] pat;
    logic exp_b;
    int idx;

    reset_n = 1'b0;
    raw_a = 1'b1; raw_b = 1'b1; raw_al = 1'b1; raw_bl = 1'b1;
    raw1_a = 1'b1;

    // Reset values with all raw inputs high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_Ta", i, Ta, 1'b0);
      chk("rst_Tb", i, Tb, 1'b0);
      chk("rst_Tal", i, Tal, 1'b0);
      chk("rst_Tbl", i, Tbl, 1'b0);
      chk("rst_tick", i, tick, 1'b0);
    end

    // Clean rise on raw_a: ticks at 3,7,11, Ta high from cycle 12.
    do_reset(2);
    raw_a = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      chk("rise_Ta", k, Ta, k >= 12);
      chk("rise_Tb", k, Tb, 1'b0);
      chk("rise_Tal", k, Tal, 1'b0);
      chk("rise_Tbl", k, Tbl, 1'b0);
      chk("rise_tick", k, tick, (k % 4) == 3);
      step();
    end

    // Glitch on raw_bl for cycles 0..5: only ticks 3 and 7 see it.
    do_reset(2);
    for (int k = 0; k <= 40; k++) begin
      raw_bl = (k <= 5);
      chk("glitch_Tbl", k, Tbl, 1'b0);
      step();
    end

    // Interrupted rise then fall on raw_b.
    // s2 high at ticks 3,7, low at 11, high at 15,19,23 -> Tb from cycle 24.
    // Drop at cycle 28: s2 low at ticks 31,35,39 -> Tb low from cycle 40.
    do_reset(2);
    for (int k = 0; k <= 44; k++) begin
      raw_b = (k < 8) || (k >= 12 && k < 28);
      exp_b = (k >= 24) && (k < 40);
      chk("intr_Tb", k, Tb, exp_b);
      chk("intr_Ta", k, Ta, 1'b0);
      chk("intr_Tal", k, Tal, 1'b0);
      chk("intr_Tbl", k, Tbl, 1'b0);
      step();
    end

    // Reset mid-debounce on raw_al: reset edge at cycle 9 after ticks 3,7.
    do_reset(2);
    raw_al = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      chk("mid_Tal", k, Tal, 1'b0);
      if (k == 9) reset_n = 1'b0;
      step();
    end
    chk("mid_rst_Tal", 9, Tal, 1'b0);
    chk("mid_rst_tick", 9, tick, 1'b0);
    reset_n = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      chk("mid_rel_Tal", j, Tal, j >= 12);
      step();
    end

    // Degenerate PRESCALE=1/DEBOUNCE=1: Ta1 follows raw1_a three cycles later.
    do_reset(2);
    pat = 24'b0011_1010_0110_1110_0001_0100;
    for (int k = 0; k <= 27; k++) begin
      raw1_a = (k < 24) ? pat[k] : 1'b0;
      idx = k - 3;
      chk("deg_Ta1", k, Ta1, (idx >= 0) ? pat[idx] : 1'b0);
      chk("deg_tick1", k, tick1, 1'b1);
      chk("deg_Tb1", k, Tb1 | Tal1 | Tbl1, 1'b0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
